// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the APB master used to reach the GPIO block.
//   - apb_state_e : transfer state machine encoding
//   - RGPIO_*     : GPIO register byte offsets on the APB bus
//   - TMO_CNT_W   : width of the wait/timeout counter (covers TIMEOUT up to 255)
package gpio_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [7:0] RGPIO_IN  = 8'h00;
    localparam logic [7:0] RGPIO_OUT = 8'h04;
    localparam logic [7:0] RGPIO_OE  = 8'h08;

    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/gpio_apb_master_if.sv
// Bus bundle for gpio_apb_master.
//   cmd_*  : command request from the client (valid/ready handshake)
//   rsp_*  : response back to the client (valid/ready handshake)
//   p*     : APB request/completion towards the GPIO slave
// Modports:
//   master : view of the APB master (drives cmd_ready, rsp_*, APB request)
//   slave  : opposite view (client + APB slave side)
interface gpio_apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, psel, penable, pwrite, pwdata
    );

endinterface

// File: rtl/gpio_apb_master_timeout_cnt.sv
// Wait-state counter for the APB ACCESS phase.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : zero the count (new transfer starting)
//   enable     : one more ACCESS cycle without pready
//   expired    : this enabled cycle brings the count to LIMIT
// The count saturates at LIMIT so it can never wrap.
module apb_timeout_cnt
    import gpio_apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LIM = TMO_CNT_W'(LIMIT);
    localparam logic [TMO_CNT_W-1:0] ONE = TMO_CNT_W'(1);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIM)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Flags the cycle that would make the count equal LIMIT, so the FSM
    // leaves ACCESS after exactly LIMIT wait cycles.
    assign expired = enable && !clear && (cnt_q >= (LIM - ONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_apb_master.sv
// Single-outstanding APB master that turns client commands into APB
// transfers (used to access the GPIO register block).
// Ports:
//   pclk    : clock, all logic on its rising edge
//   presetn : synchronous active-low reset, aborts any transfer in flight
//   bus     : gpio_apb_master_if.master -- command, response and APB signals
// Every output comes straight from a flop; the flop inputs are derived
// from the next state, so outputs line up with the state they describe.
module gpio_apb_master
    import gpio_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    gpio_apb_master_if.master bus
);

    apb_state_e        state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic accept;
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    assign accept     = (state_q == ST_IDLE) && bus.cmd_valid;
    assign tmo_clear  = accept;
    assign tmo_enable = (state_q == ST_ACCESS) && !bus.pready;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk     (pclk),
        .rst_n   (presetn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Next-state logic; pready wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (bus.pready || tmo_expired) state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output flop inputs.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
        end

        if (state_q == ST_ACCESS) begin
            if (bus.pready) begin
                rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                rsp_err_d   = bus.pslverr;
            end else if (tmo_expired) begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_apb_master.sv
// Bench for gpio_apb_master: directed scenarios with literal expectations
// followed by randomized transfers, all checked against a transaction-level
// reference model.
module tb_gpio_apb_master;
    import gpio_apb_pkg::*;

    localparam int TMO = 16;

    logic pclk;
    logic presetn;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    gpio_apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus();

    gpio_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, cycle=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave behaviour plan for the current transfer.
    int          wait_plan = 0;
    bit          err_plan  = 0;
    int          rsp_hold  = 0;
    logic [31:0] rd_plan   = '0;
    int          acc_cnt   = 0;
    int          rv_cnt    = 0;
    int          last_acc  = 0;

    // APB slave and response consumer; junk on pready/prdata/pslverr
    // whenever the master is not in an access phase.
    always @(negedge pclk) begin
        if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
            if (acc_cnt == wait_plan) begin
                bus.pready  = 1'b1;
                bus.prdata  = rd_plan;
                bus.pslverr = err_plan;
            end else begin
                bus.pready  = 1'b0;
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end
            acc_cnt++;
        end else begin
            acc_cnt     = 0;
            bus.pready  = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
        end
        if (bus.rsp_valid === 1'b1) begin
            bus.rsp_ready = (rv_cnt >= rsp_hold);
            rv_cnt++;
        end else begin
            rv_cnt        = 0;
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Reference model: one outstanding transaction described by its age
    // (edges since acceptance) and whether its response is pending.
    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_wr   = 0;
    bit          m_err  = 0;
    int          m_age  = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;

    always @(posedge pclk) begin
        if (!presetn) begin
            m_live  = 1;
            m_busy  = 0;
            m_done  = 0;
            m_rdata = '0;
            m_err   = 0;
        end else if (!m_busy) begin
            if (bus.cmd_valid) begin
                m_busy  = 1;
                m_age   = 1;
                m_addr  = bus.cmd_addr;
                m_wr    = bus.cmd_write;
                m_wdata = bus.cmd_write ? bus.cmd_wdata : 32'h0;
            end
        end else if (!m_done) begin
            // age 1 is the setup cycle; age k>=2 is access cycle k-1
            if (m_age >= 2 && bus.pready) begin
                m_done  = 1;
                m_rdata = m_wr ? 32'h0 : bus.prdata;
                m_err   = bus.pslverr;
            end else if (m_age - 1 >= TMO) begin
                m_done  = 1;
                m_rdata = 32'h0;
                m_err   = 1;
            end else begin
                m_age++;
            end
        end else if (bus.rsp_ready) begin
            m_busy = 0;
            m_done = 0;
        end
    end

    always @(negedge pclk) begin
        if (m_live) begin
            chk("cmd_ready", bus.cmd_ready, !m_busy);
            chk("psel",      bus.psel,      m_busy && !m_done);
            chk("penable",   bus.penable,   m_busy && !m_done && m_age >= 2);
            chk("rsp_valid", bus.rsp_valid, m_done);
            if (m_busy && !m_done) begin
                chk("paddr",  bus.paddr,  m_addr);
                chk("pwrite", bus.pwrite, m_wr);
                chk("pwdata", bus.pwdata, m_wdata);
            end
            if (m_done) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_err",   bus.rsp_err,   m_err);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge right after
    // the accepting rising edge (the setup cycle).
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int waits, input bit err, input int hold);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_wait: cmd_ready never high within %0d cycles", n);
        end
        wait_plan = waits;
        err_plan  = err;
        rsp_hold  = hold;
        rd_plan   = rd;
        @(negedge pclk);
        last_acc      = cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("idle_reached", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        int a_acc;
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge pclk);
        chk("rst_psel",      bus.psel,      1'b0);
        chk("rst_penable",   bus.penable,   1'b0);
        chk("rst_pwrite",    bus.pwrite,    1'b0);
        chk("rst_paddr",     bus.paddr,     32'h0);
        chk("rst_pwdata",    bus.pwdata,    32'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err",   bus.rsp_err,   1'b0);
        presetn = 1'b1;
        @(negedge pclk);
        chk("rel_cmd_ready", bus.cmd_ready, 1'b1);

        // zero-wait write
        issue(1'b1, 32'(RGPIO_OUT), 32'hABCD_1234, 32'h0, 0, 1'b0, 0);
        chk("w0_setup_psel",    bus.psel,    1'b1);
        chk("w0_setup_penable", bus.penable, 1'b0);
        chk("w0_pwdata",        bus.pwdata,  32'hABCD_1234);
        chk("w0_paddr",         bus.paddr,   32'h4);
        @(negedge pclk);
        chk("w0_acc_penable",   bus.penable, 1'b1);
        @(negedge pclk);
        chk("w0_rsp_valid",     bus.rsp_valid, 1'b1);
        chk("w0_rsp_err",       bus.rsp_err,   1'b0);
        chk("w0_psel_low",      bus.psel,      1'b0);
        wait_idle();

        // read with three wait states
        @(negedge pclk);
        issue(1'b0, 32'(RGPIO_IN), 32'hFFFF_FFFF, 32'hA5A5_9C9C, 3, 1'b0, 0);
        for (int k = 1; k <= 5; k++) begin
            chk("r3_psel",      bus.psel,      1'b1);
            chk("r3_paddr",     bus.paddr,     32'h0);
            chk("r3_no_rsp",    bus.rsp_valid, 1'b0);
            @(negedge pclk);
        end
        chk("r3_rsp_valid", bus.rsp_valid, 1'b1);
        chk("r3_rsp_rdata", bus.rsp_rdata, 32'hA5A5_9C9C);
        chk("r3_rsp_err",   bus.rsp_err,   1'b0);
        wait_idle();

        // read that never gets pready: abort after TMO access cycles
        @(negedge pclk);
        issue(1'b0, 32'(RGPIO_OE), 32'h0, 32'h1234_5678, 255, 1'b0, 0);
        repeat (16) @(negedge pclk);
        chk("to_last_psel",    bus.psel,      1'b1);
        chk("to_last_penable", bus.penable,   1'b1);
        chk("to_last_no_rsp",  bus.rsp_valid, 1'b0);
        @(negedge pclk);
        chk("to_rsp_valid", bus.rsp_valid, 1'b1);
        chk("to_rsp_err",   bus.rsp_err,   1'b1);
        chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("to_psel",      bus.psel,      1'b0);
        chk("to_penable",   bus.penable,   1'b0);
        wait_idle();

        // write with pslverr, response stalled for four cycles
        @(negedge pclk);
        issue(1'b1, 32'(RGPIO_OE), 32'hDEAD_BEAD, 32'h0, 0, 1'b1, 4);
        repeat (2) @(negedge pclk);
        for (int k = 0; k < 4; k++) begin
            chk("se_rsp_valid", bus.rsp_valid, 1'b1);
            chk("se_rsp_err",   bus.rsp_err,   1'b1);
            chk("se_rsp_rdata", bus.rsp_rdata, 32'h0);
            chk("se_cmd_ready", bus.cmd_ready, 1'b0);
            @(negedge pclk);
        end
        chk("se_still_valid", bus.rsp_valid, 1'b1);
        @(negedge pclk);
        chk("se_done_ready", bus.cmd_ready, 1'b1);
        chk("se_done_valid", bus.rsp_valid, 1'b0);

        // reset in the middle of ACCESS
        issue(1'b1, 32'(RGPIO_OUT), 32'h5A5A_0F0F, 32'h0, 255, 1'b0, 0);
        @(negedge pclk);
        chk("ra_in_access", bus.penable, 1'b1);
        presetn = 1'b0;
        @(negedge pclk);
        chk("ra_psel",      bus.psel,      1'b0);
        chk("ra_penable",   bus.penable,   1'b0);
        chk("ra_rsp_valid", bus.rsp_valid, 1'b0);
        chk("ra_paddr",     bus.paddr,     32'h0);
        chk("ra_pwdata",    bus.pwdata,    32'h0);
        presetn = 1'b1;
        @(negedge pclk);
        chk("ra_cmd_ready", bus.cmd_ready, 1'b1);
        chk("ra_no_psel",   bus.psel,      1'b0);

        // back-to-back commands
        issue(1'b1, 32'(RGPIO_OUT), 32'h0000_0011, 32'h0, 0, 1'b0, 0);
        a_acc = last_acc;
        issue(1'b0, 32'(RGPIO_IN), 32'h0, 32'h0F0F_1234, 0, 1'b0, 0);
        chk("b2b_spacing", 32'(last_acc - a_acc), 32'd4);
        chk("b2b_psel",    bus.psel,  1'b1);
        chk("b2b_paddr",   bus.paddr, 32'h0);
        wait_idle();

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            int          r;
            int          waits;
            logic [31:0] addr;
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            r = $urandom_range(0, 9);
            waits = (r < 6) ? r : (r == 6) ? TMO - 1 : (r == 7) ? TMO : (r == 8) ? 255 : 1;
            case ($urandom_range(0, 3))
                0:       addr = 32'(RGPIO_IN);
                1:       addr = 32'(RGPIO_OUT);
                2:       addr = 32'(RGPIO_OE);
                default: addr = $urandom;
            endcase
            issue(1'($urandom_range(0, 1)), addr, $urandom, $urandom, waits,
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end
        wait_idle();
        repeat (2) @(negedge pclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
